// File: rtl/shift_register_pkg.sv
// Shared types and helpers for the shift_register datapath.
// Optional feature macro: ROTATE_EN (enables ROL/ROR modes).
package shift_register_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    SRA  = 3'd4,
    ROL  = 3'd5,
    ROR  = 3'd6,
    RSVD = 3'd7
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True for modes that move bits and therefore may drive a burst.
  function automatic logic is_shift_mode(input mode_t m);
    logic r;
    case (m)
      SHL, SHR, SRA: r = 1'b1;
`ifdef ROTATE_EN
      ROL, ROR:      r = 1'b1;
`else
      ROL, ROR:      r = 1'b0;
`endif
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_register_shift_unit.sv
// Combinational one-step shifter shared by the single-shift and burst paths.
// Optional feature macro: ROTATE_EN (ROL/ROR; otherwise they pass the value through).
module shift_unit
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  mode_t            i_mode,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_value,
  output logic             o_ser_out
);

  // Next value and the bit that leaves the register for the selected mode.
  always_comb begin
    o_value   = i_value;
    o_ser_out = 1'b0;
    case (i_mode)
      SHL: begin
        o_value   = {i_value[WIDTH-2:0], i_ser_in};
        o_ser_out = i_value[WIDTH-1];
      end
      SHR: begin
        o_value   = {i_ser_in, i_value[WIDTH-1:1]};
        o_ser_out = i_value[0];
      end
      SRA: begin
        o_value   = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
        o_ser_out = i_value[0];
      end
`ifdef ROTATE_EN
      ROL: begin
        o_value   = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
        o_ser_out = i_value[WIDTH-1];
      end
      ROR: begin
        o_value   = {i_value[0], i_value[WIDTH-1:1]};
        o_ser_out = i_value[0];
      end
`endif
      default: begin
        o_value   = i_value;
        o_ser_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register.sv
// Multi-mode shift/load register with an autonomous N-shift burst engine.
// Optional feature macro: ROTATE_EN (ROL/ROR modes, also valid as burst modes).
module shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_ena,
  input  logic             sclr_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] datain,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] reg_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  mode_t            w_mode_in;
  mode_t            w_shift_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_ser_bit;

  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_reg;
  logic             r_ser_out;
  logic             r_busy;
  logic             r_done;

  assign w_mode_in    = mode_t'(mode);
  // While bursting, the latched mode drives the shifter; external mode is ignored.
  assign w_shift_mode = (r_state == SHIFT) ? r_mode : w_mode_in;

  shift_unit #(.WIDTH(WIDTH)) u_shift_unit (
    .i_value   (r_reg),
    .i_mode    (w_shift_mode),
    .i_ser_in  (ser_in),
    .o_value   (w_next),
    .o_ser_out (w_ser_bit)
  );

  // Burst FSM, counter and data register; priority rst > clk_ena > sclr_n > burst > mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= HOLD;
      r_count   <= '0;
      r_reg     <= '0;
      r_ser_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (clk_ena) begin
      r_done <= 1'b0;
      if (!sclr_n) begin
        r_state   <= IDLE;
        r_count   <= '0;
        r_reg     <= '0;
        r_ser_out <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              // The start cycle belongs to the burst: the register is untouched.
              if ((burst_len != '0) && is_shift_mode(w_mode_in)) begin
                r_mode  <= w_mode_in;
                r_count <= burst_len;
                r_busy  <= 1'b1;
                r_state <= SHIFT;
              end else begin
                r_done <= 1'b1;
              end
            end else if (w_mode_in == LOAD) begin
              r_reg <= datain;
            end else if (is_shift_mode(w_mode_in)) begin
              r_reg     <= w_next;
              r_ser_out <= w_ser_bit;
            end
          end
          SHIFT: begin
            r_reg     <= w_next;
            r_ser_out <= w_ser_bit;
            r_count   <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign reg_out = r_reg;
  assign ser_out = r_ser_out;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the register behaviour.
module tb_shift_register;

  localparam int W    = 16;
  localparam int CW   = $clog2(W + 1);
  localparam longint TOP  = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_ena;
  logic          sclr_n;
  logic [2:0]    mode;
  logic [W-1:0]  datain;
  logic          ser_in;
  logic          start;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  reg_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: value as a plain integer, bursts as "shifts remaining".
  longint m_val;
  bit     m_ser, m_done;
  int     m_left;
  int     m_mode;

  shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_ena   (clk_ena),
    .sclr_n    (sclr_n),
    .mode      (mode),
    .datain    (datain),
    .ser_in    (ser_in),
    .start     (start),
    .burst_len (burst_len),
    .reg_out   (reg_out),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic bit rot_ok();
`ifdef ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit shiftable(int md);
    return (md == 2 || md == 3 || md == 4 || (rot_ok() && (md == 5 || md == 6)));
  endfunction

  // One shift of the model value using integer arithmetic.
  function automatic void mdl_shift(int md, bit s);
    bit top_bit, low_bit;
    top_bit = (m_val >= HALF);
    low_bit = m_val[0];
    case (md)
      2: begin m_ser = top_bit; m_val = (m_val * 2 + longint'(s)) % TOP; end
      3: begin m_ser = low_bit; m_val = m_val / 2 + longint'(s) * HALF; end
      4: begin m_ser = low_bit; m_val = m_val / 2 + longint'(top_bit) * HALF; end
      5: begin m_ser = top_bit; m_val = (m_val * 2) % TOP + longint'(top_bit); end
      6: begin m_ser = low_bit; m_val = m_val / 2 + longint'(low_bit) * HALF; end
      default: ;
    endcase
  endfunction

  function automatic void mdl_reset();
    m_val = 0; m_ser = 0; m_done = 0; m_left = 0; m_mode = 0;
  endfunction

  // Apply one rising edge to the model using the currently driven inputs.
  function automatic void mdl_edge();
    if (rst) begin mdl_reset(); return; end
    if (!clk_ena) return;
    m_done = 0;
    if (!sclr_n) begin
      m_val = 0; m_ser = 0; m_left = 0;
    end else if (m_left > 0) begin
      mdl_shift(m_mode, ser_in);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (start) begin
      if (burst_len != 0 && shiftable(int'(mode))) begin
        m_mode = int'(mode);
        m_left = int'(burst_len);
      end else begin
        m_done = 1;
      end
    end else if (mode == 3'd1) begin
      m_val = longint'(datain);
    end else if (shiftable(int'(mode))) begin
      mdl_shift(int'(mode), ser_in);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".reg"},  32'(reg_out), 32'(m_val));
    chk({tag, ".ser"},  32'(ser_out), 32'(m_ser));
    chk({tag, ".busy"}, 32'(busy),    32'(m_left > 0));
    chk({tag, ".done"}, 32'(done),    32'(m_done));
  endtask

  // Advance one clock, update the model, sample outputs 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    mdl_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic idle_in();
    clk_ena = 1; sclr_n = 1; mode = 3'd0; datain = '0; ser_in = 0; start = 0; burst_len = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    idle_in(); mode = 3'd1; datain = v;
    step("load");
    mode = 3'd0;
  endtask

  task automatic burst_start(input logic [2:0] md, input int len);
    idle_in(); mode = md; burst_len = CW'(len); start = 1;
    step("bstart");
    start = 0; mode = 3'd0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    mdl_reset();
    #12;
    chk("reset.reg", 32'(reg_out), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 0;

    // Asynchronous reset clears a loaded value without a clock edge.
    load(16'hFFFF);
    chk("load_ffff", 32'(reg_out), 32'hFFFF);
    #2 rst = 1;
    mdl_reset();
    #1 chk("async_rst", 32'(reg_out), 32'h0);
    @(negedge clk);
    rst = 0;

    // Synchronous clear beats LOAD.
    idle_in(); mode = 3'd1; datain = 16'hF0F0; sclr_n = 0;
    step("sclr_load");
    chk("sclr_load_val", 32'(reg_out), 32'h0);

    // Load, then hold with clk_ena low while SHL is selected.
    load(16'hAAAA);
    chk("load_aaaa", 32'(reg_out), 32'hAAAA);
    idle_in(); clk_ena = 0; mode = 3'd2; ser_in = 1;
    step("ena_hold");
    chk("ena_hold_val", 32'(reg_out), 32'hAAAA);

    // Single shifts.
    load(16'h8001);
    idle_in(); mode = 3'd2; ser_in = 0;
    step("shl");
    chk("shl_val", 32'(reg_out), 32'h0002);
    chk("shl_ser", 32'(ser_out), 32'h1);
    load(16'h8001);
    idle_in(); mode = 3'd4;
    step("sra");
    chk("sra_val", 32'(reg_out), 32'hC000);
    chk("sra_ser", 32'(ser_out), 32'h1);

    // SHR burst of 4; a second start mid-burst is ignored.
    load(16'h00FF);
    burst_start(3'd3, 4);
    chk("b_busy0", 32'(busy), 32'h1);
    chk("b_reg0", 32'(reg_out), 32'h00FF);
    idle_in(); start = 1; mode = 3'd1; datain = 16'h5555; burst_len = CW'(2);
    step("b_e1");
    idle_in();
    step("b_e2");
    step("b_e3");
    chk("b_busy3", 32'(busy), 32'h1);
    step("b_e4");
    chk("b_reg4", 32'(reg_out), 32'h000F);
    chk("b_done4", 32'(done), 32'h1);
    chk("b_busy4", 32'(busy), 32'h0);
    step("b_e5");
    chk("b_done5", 32'(done), 32'h0);

    // Zero-length burst: no change, done on the next cycle.
    burst_start(3'd2, 0);
    chk("z_reg", 32'(reg_out), 32'h000F);
    chk("z_done", 32'(done), 32'h1);
    chk("z_busy", 32'(busy), 32'h0);

    // Synchronous clear mid-burst aborts without done.
    load(16'h00FF);
    burst_start(3'd3, 4);
    idle_in();
    step("c_e1");
    sclr_n = 0;
    step("c_clr");
    chk("c_reg", 32'(reg_out), 32'h0);
    chk("c_busy", 32'(busy), 32'h0);
    chk("c_done", 32'(done), 32'h0);
    idle_in();
    step("c_after");
    chk("c_done_after", 32'(done), 32'h0);

    // clk_ena low for 3 cycles mid-burst delays completion by 3 cycles.
    load(16'h00FF);
    burst_start(3'd3, 4);
    idle_in();
    step("s_e1");
    clk_ena = 0;
    for (int i = 0; i < 3; i++) step("s_stall");
    chk("s_busy_stall", 32'(busy), 32'h1);
    chk("s_reg_stall", 32'(reg_out), 32'h007F);
    clk_ena = 1;
    step("s_e2");
    step("s_e3");
    chk("s_done_e3", 32'(done), 32'h0);
    step("s_e4");
    chk("s_reg_end", 32'(reg_out), 32'h000F);
    chk("s_done_end", 32'(done), 32'h1);

    // ROL burst of WIDTH restores the value; without rotate it completes immediately.
    load(16'h1234);
    burst_start(3'd5, 16);
`ifdef ROTATE_EN
    chk("rol_busy", 32'(busy), 32'h1);
    idle_in();
    for (int i = 0; i < 16; i++) step("rol_shift");
    chk("rol_reg", 32'(reg_out), 32'h1234);
    chk("rol_done", 32'(done), 32'h1);
`else
    chk("rol_reg", 32'(reg_out), 32'h1234);
    chk("rol_done", 32'(done), 32'h1);
    chk("rol_busy", 32'(busy), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      clk_ena   = ($urandom_range(0, 9) != 0);
      sclr_n    = ($urandom_range(0, 39) != 0);
      mode      = 3'($urandom_range(0, 7));
      datain    = W'($urandom);
      ser_in    = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 5) == 0);
      burst_len = CW'($urandom_range(0, 20));
      step("rand");
    end

    // Reset mid-activity returns to reset values.
    idle_in();
    load(16'h00FF);
    burst_start(3'd2, 10);
    step("r_e1");
    #2 rst = 1;
    mdl_reset();
    #1;
    chk_model("rst_mid");
    chk("rst_mid_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 0;
    step("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register.md
# shift_register

Parametrised, multi-mode shift/load register for the sequential multiplier datapath: the next generation of the plain enable/clear register. It adds logical/arithmetic shifting with serial in/out, an optional rotate, and a burst engine that performs N shifts autonomously and flags completion. It holds the multiplier and partial-product operands that the multiplier control FSM steps one bit per cycle.

## Interface
- WIDTH, 16: register width in bits, ≥ 2.
- CNT_W, $clog2(WIDTH+1): width of burst_len and of the internal shift counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clk_ena  in  1  global enable; when low, every register holds.
- sclr_n  in  1  synchronous clear, active low; honoured only when clk_ena=1.
- mode  in  3  operation select (see Operation).
- datain  in  WIDTH  parallel load data.
- ser_in  in  1  serial input bit for SHL/SHR.
- start  in  1  single-cycle burst request.
- burst_len  in  CNT_W  number of shifts in a burst.
- reg_out  out  WIDTH  register contents.
- ser_out  out  1  registered last bit shifted out.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse on burst completion.

## Operation
- Mode encoding: 0 HOLD; 1 LOAD (reg_out<=datain); 2 SHL (ser_in into LSB, MSB to ser_out); 3 SHR (ser_in into MSB, LSB to ser_out); 4 SRA (MSB replicated, LSB to ser_out); 5 ROL; 6 ROR (ser_out = the bit that wrapped); 7 reserved, behaves as HOLD.
- Update priority per edge: rst > clk_ena=0 (hold all) > sclr_n=0 > burst > mode.
- sclr_n=0 with clk_ena=1: reg_out<=0, ser_out<=0, burst aborted (busy<=0), done<=0, state IDLE.
- FSM states: IDLE, SHIFT.
- IDLE: mode applied every enabled cycle. If start=1, the start cycle is consumed by the burst; the mode is not applied in that cycle.
  - start=1, burst_len>0, mode a shift mode: latch mode, count<=burst_len, busy<=1, go to SHIFT. The register does not change in that cycle.
  - start=1 with burst_len=0, or with a non-shift mode (HOLD, LOAD, 7, or 5/6 when rotate is compiled out): no change to reg_out; done pulses next cycle; stay IDLE.
- SHIFT: one shift of the latched mode per enabled cycle; count decrements. On the edge performing the final shift: state<=IDLE, busy<=0, done<=1. mode, start, datain and ser_in-driven loads are ignored while busy. ser_in is still sampled each shift.
- done is a registered pulse: high for exactly one enabled cycle, then cleared.
- burst_len above WIDTH is legal. Shifting continues; SHL/SHR fill entirely with ser_in.

## Timing
- Reset values: reg_out=0, ser_out=0, busy=0, done=0, state IDLE, count=0.
- LOAD and single shift: result visible on reg_out 1 cycle after the sampling edge.
- Burst of N (N>0): start sampled at edge E0. Shifts occur at edges E1..EN. busy is high from after E0 until EN. done is high between EN and EN+1. Total N+1 enabled cycles.
- clk_ena low mid-burst stalls the burst: no shift, no count change, and done, busy and ser_out hold.
- rst mid-burst returns immediately to the reset values.

## Configuration
- ROTATE_EN defined: modes 5 ROL and 6 ROR are implemented, and both are valid burst modes.
- ROTATE_EN undefined: modes 5 and 6 behave as HOLD. A burst started with either completes as a zero-length burst.

## Structure
- Shared package shift_register_pkg holds:
  - the mode_t enum: HOLD, LOAD, SHL, SHR, SRA, ROL, ROR, RSVD.
  - the state_t enum: IDLE, SHIFT.
  - the is_shift_mode() function.
- One natural sub-module, shift_unit. It is combinational: it takes the value, mode and ser_in and returns the next value and the shifted-out bit. It is shared by the single-shift and burst paths.
- The FSM and counter live in the top module.

## Test plan
- Reset/clear: assert rst with reg_out=16'hFFFF → reg_out=0 immediately. LOAD 16'hF0F0 with sclr_n=0, clk_ena=1 → reg_out=0 next cycle.
- Load and enable: LOAD 16'hAAAA → 16'hAAAA. Then clk_ena=0 while in SHL → value held.
- Single shifts from 16'h8001:
  - SHL with ser_in=0 → 16'h0002, ser_out=1.
  - SRA from 16'h8001 → 16'hC000, ser_out=1.
- Burst: from 16'h00FF, start with SHR, burst_len=4, ser_in=0 → busy high for 4 shifts, then reg_out=16'h000F and done pulses once, 5 cycles after start. A start issued mid-burst is ignored.
- Boundaries:
  - burst_len=0 → no change, done the next cycle.
  - sclr_n=0 mid-burst → reg_out=0, busy=0, no done.
  - clk_ena low for 3 cycles mid-burst → completion delayed by 3 cycles.
- ROTATE_EN: burst ROL with burst_len=16 on 16'h1234 → 16'h1234 restored with done. Without the macro, the same burst leaves 16'h1234 unchanged with done the next cycle.
